nn_eval_stage: RTL and testbench

- Downstream neighbour of the training core's sigmoid stage; consumes the 40 per-sample predictions ycap (Q1.8, 0..256 = 0.0..1.0) produced each epoch.
- Compares each prediction against the fixed label rule: samples 0..19 have label 1.0, samples 20..39 have label 0.0.
- Per epoch, reports the classification correct count, the sum of squared errors and a converged flag; keeps a running epoch counter for the host/ILA.

---
 rtl/nn_pkg.sv | 21 ++
 rtl/nn_sq_err.sv | 62 ++++++
 rtl/nn_eval_stage.sv | 130 +++++++++++++
 tb/tb_nn_eval_stage.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared constants and types for the training core and its evaluation stage.
package nn_pkg;

  // Q1.8 representation of 1.0.
  localparam int unsigned Q8_ONE    = 256;
  // Predictions per epoch.
  localparam int unsigned N_SAMPLES = 40;
  // Leading samples that carry label 1.0; the rest carry 0.0.
  localparam int unsigned N_POS     = 20;
  // Signed width of ycap as produced by the sigmoid stage.
  localparam int unsigned YCAP_W    = 10;

  // Evaluation sequencing.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } eval_state_t;

endpackage

// File: rtl/nn_sq_err.sv
// Per-sample error unit: clamps a ycap to [0, ONE], selects the label,
// classifies against the threshold and registers the squared error.
module nn_sq_err #(
  parameter int unsigned YW     = nn_pkg::YCAP_W,
  parameter int unsigned ONE    = nn_pkg::Q8_ONE,
  parameter int unsigned THRESH = 128,
  parameter int unsigned SQW    = $clog2(ONE * ONE + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,     // a sample is consumed this cycle
  input  logic           pos,    // sample carries label ONE
  input  logic [YW-1:0]  data,   // signed ycap
  output logic           hit,    // combinational: sample classified correctly
  output logic [SQW-1:0] sq,     // registered squared error
  output logic           sq_vld
);

  localparam logic signed [YW-1:0] ONE_S = YW'(ONE);
  localparam logic signed [YW-1:0] THR_S = YW'(THRESH);

  logic signed [YW-1:0]   x;
  logic signed [YW-1:0]   clamped;
  logic signed [YW-1:0]   label;
  logic signed [YW:0]     err;
  logic signed [2*YW+1:0] prod;
  logic                   unused_prod_hi;

  assign x = $signed(data);

  // Clamp out-of-range predictions before any arithmetic.
  always_comb begin
    clamped = x;
    if (x < 0) begin
      clamped = '0;
    end else if (x > ONE_S) begin
      clamped = ONE_S;
    end
  end

  assign label = pos ? ONE_S : '0;
  assign err   = $signed({clamped[YW-1], clamped}) - $signed({label[YW-1], label});
  assign prod  = err * err;
  assign hit   = ((clamped >= THR_S) == pos);

  // Square never exceeds ONE^2, so the upper product bits are always zero.
  assign unused_prod_hi = ^prod[2*YW+1:SQW];

  // Stage 1 of the square pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sq     <= '0;
      sq_vld <= 1'b0;
    end else begin
      sq_vld <= en;
      if (en) begin
        sq <= prod[SQW-1:0];
      end
    end
  end

endmodule

// File: rtl/nn_eval_stage.sv
// Per-epoch evaluation of the sigmoid stage output: correct count, sum of
// squared errors, convergence flag and a running epoch counter.
module nn_eval_stage #(
  parameter int unsigned N_SAMPLES = nn_pkg::N_SAMPLES,
  parameter int unsigned N_POS     = nn_pkg::N_POS,
  parameter int unsigned YW        = nn_pkg::YCAP_W,
  parameter int unsigned ONE       = nn_pkg::Q8_ONE,
  parameter int unsigned THRESH    = 128,
  parameter int unsigned ERRW      = 24,
  parameter int unsigned EPW       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [YW-1:0]   in_data,
  output logic            busy,
  output logic            done,
  output logic [5:0]      correct_cnt,
  output logic [ERRW-1:0] sse,
  output logic            converged,
  output logic [EPW-1:0]  epoch_cnt
);

  import nn_pkg::*;

  localparam int unsigned IW  = $clog2(N_SAMPLES);
  localparam int unsigned SQW = $clog2(ONE * ONE + 1);

  eval_state_t     state_q, state_d;
  logic [IW-1:0]   idx_q;
  logic [5:0]      cnt_q;
  logic [ERRW-1:0] acc_q, acc_d;
  logic [ERRW:0]   acc_sum;

  logic            xfer;
  logic            pos;
  logic            last;
  logic            hit;
  logic [SQW-1:0]  sq;
  logic            sq_vld;

  assign in_ready = (state_q == ACCUM);
  assign busy     = (state_q == ACCUM) || (state_q == DRAIN);
  assign done     = (state_q == DONE);

  assign xfer = in_valid && in_ready;
  assign pos  = (idx_q < IW'(N_POS));
  assign last = (idx_q == IW'(N_SAMPLES - 1));

  nn_sq_err #(
    .YW     (YW),
    .ONE    (ONE),
    .THRESH (THRESH),
    .SQW    (SQW)
  ) u_sq_err (
    .clk    (clk),
    .rst    (rst),
    .en     (xfer),
    .pos    (pos),
    .data   (in_data),
    .hit    (hit),
    .sq     (sq),
    .sq_vld (sq_vld)
  );

  // Stage 2 of the square pipeline: saturating accumulate.
  always_comb begin
    acc_sum = {1'b0, acc_q} + (ERRW + 1)'(sq);
    acc_d   = acc_q;
    if (sq_vld) begin
      acc_d = acc_sum[ERRW] ? '1 : acc_sum[ERRW-1:0];
    end
  end

  // Next-state: one pass IDLE -> ACCUM -> DRAIN -> DONE -> IDLE per start.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (xfer && last) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sample index, correct count and SSE accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start) begin
        idx_q <= '0;
        cnt_q <= '0;
        acc_q <= '0;
      end else begin
        if (xfer) begin
          idx_q <= idx_q + IW'(1);
          cnt_q <= cnt_q + 6'(hit);
        end
        acc_q <= acc_d;
      end
    end
  end

  // Results are captured as DRAIN closes, folding in the last square, so
  // they are already valid in the cycle that done is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      correct_cnt <= '0;
      sse         <= '0;
      converged   <= 1'b0;
      epoch_cnt   <= '0;
    end else if (state_q == DRAIN) begin
      correct_cnt <= cnt_q;
      sse         <= acc_d;
      converged   <= (cnt_q == 6'(N_SAMPLES));
      if (epoch_cnt != '1) begin
        epoch_cnt <= epoch_cnt + EPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_nn_eval_stage.sv
// Directed bench for nn_eval_stage with an epoch-level reference model.
module tb_nn_eval_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [9:0]  in_data;
  logic        busy;
  logic        done;
  logic [5:0]  correct_cnt;
  logic [23:0] sse;
  logic        converged;
  logic [15:0] epoch_cnt;

  int errors = 0;
  int checks = 0;

  int vals [40];

  // Reference model state.
  bit m_acc;
  int m_n;
  int m_tail;
  int m_samp [40];
  int e_cc, e_sse, e_conv, e_ep;

  nn_eval_stage dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .busy        (busy),
    .done        (done),
    .correct_cnt (correct_cnt),
    .sse         (sse),
    .converged   (converged),
    .epoch_cnt   (epoch_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Epoch results straight from the labelling and error rules.
  task automatic publish();
    int s = 0;
    int c = 0;
    for (int i = 0; i < 40; i++) begin
      int v = m_samp[i];
      int l = (i < 20) ? 256 : 0;
      if (v < 0) v = 0;
      if (v > 256) v = 256;
      s += (v - l) * (v - l);
      if ((v >= 128) == (i < 20)) c++;
    end
    if (s > 16777215) s = 16777215;
    e_cc   = c;
    e_sse  = s;
    e_conv = (c == 40) ? 1 : 0;
    if (e_ep < 65535) e_ep++;
  endtask

  // Model: accept a start when idle, take 40 samples, results appear two
  // cycles after the last one and stay until the next epoch completes.
  initial begin
    m_acc = 0; m_n = 0; m_tail = 0;
    e_cc = 0; e_sse = 0; e_conv = 0; e_ep = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_acc = 0; m_n = 0; m_tail = 0;
        e_cc = 0; e_sse = 0; e_conv = 0; e_ep = 0;
      end else if (m_tail > 0) begin
        m_tail--;
        if (m_tail == 1) publish();
      end else if (m_acc) begin
        if (in_valid) begin
          m_samp[m_n] = int'($signed(in_data));
          m_n++;
          if (m_n == 40) begin
            m_acc  = 0;
            m_tail = 2;
          end
        end
      end else if (start) begin
        m_acc = 1;
        m_n   = 0;
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", in_ready, m_acc ? 1 : 0);
      chk("busy", busy, (m_acc || m_tail == 2) ? 1 : 0);
      chk("done", done, (m_tail == 1) ? 1 : 0);
      chk("correct_cnt", correct_cnt, e_cc);
      chk("sse", sse, e_sse);
      chk("converged", converged, e_conv);
      chk("epoch_cnt", epoch_cnt, e_ep);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_perfect();
    for (int i = 0; i < 40; i++) vals[i] = (i < 20) ? 256 : 0;
  endtask

  // Start an epoch and feed n_send samples; waits for done if all 40 sent.
  task automatic run_epoch(input int gap, input bit busy_starts, input bit coincide,
                           input int n_send);
    int guard;
    int lat;
    start = 1'b1;
    if (coincide) begin
      in_valid = 1'b1;
      in_data  = 10'd0;
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < n_send; i++) begin
      in_valid = 1'b1;
      in_data  = 10'(vals[i]);
      guard    = 0;
      while (!in_ready && guard < 50) begin
        tick();
        guard++;
      end
      if (guard >= 50) chk("ready_wait", 0, 1);
      if (busy_starts && (i == 3 || i == 25)) start = 1'b1;
      tick();
      start    = 1'b0;
      in_valid = 1'b0;
      in_data  = 10'h3ff;
      if (i < n_send - 1) begin
        for (int g = 0; g < gap; g++) begin
          chk("stall_ready", in_ready, 1);
          tick();
        end
      end
    end
    if (n_send == 40) begin
      lat = 1;
      while (!done && lat < 8) begin
        tick();
        lat++;
      end
      chk("done_latency", lat, 2);
    end
  endtask

  task automatic expect_res(input string tag, input int cc, input int s, input int conv,
                            input int ep);
    chk({tag, "_cc"}, correct_cnt, cc);
    chk({tag, "_sse"}, sse, s);
    chk({tag, "_conv"}, converged, conv);
    chk({tag, "_epoch"}, epoch_cnt, ep);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) tick();
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    expect_res("rst", 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    // Perfect predictions.
    set_perfect();
    run_epoch(0, 1'b0, 1'b0, 40);
    expect_res("perfect", 40, 0, 1, 1);
    repeat (3) tick();

    // All-half predictions.
    for (int i = 0; i < 40; i++) vals[i] = 128;
    run_epoch(0, 1'b0, 1'b0, 40);
    expect_res("half", 20, 655360, 0, 2);
    repeat (2) tick();

    // Threshold boundary.
    for (int i = 0; i < 40; i++) vals[i] = (i < 20) ? 127 : 128;
    run_epoch(0, 1'b0, 1'b0, 40);
    expect_res("thresh", 0, 660500, 0, 3);
    repeat (2) tick();

    // Clamp and stall.
    set_perfect();
    vals[0]  = 300;
    vals[39] = -5;
    run_epoch(3, 1'b0, 1'b0, 40);
    expect_res("clamp", 40, 0, 1, 4);
    repeat (2) tick();

    // Reset mid-epoch.
    set_perfect();
    run_epoch(0, 1'b0, 1'b0, 10);
    rst = 1'b1;
    #1;
    chk("midrst_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    expect_res("midrst", 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    tick();
    run_epoch(0, 1'b0, 1'b0, 40);
    expect_res("after_rst", 40, 0, 1, 1);
    repeat (2) tick();

    // Start while busy, and start coincident with a sample in IDLE.
    run_epoch(0, 1'b1, 1'b1, 40);
    expect_res("busy_start1", 40, 0, 1, 2);
    tick();
    chk("single_done", done, 0);
    repeat (2) tick();
    run_epoch(1, 1'b1, 1'b0, 40);
    expect_res("busy_start2", 40, 0, 1, 3);
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
